// File: rtl/sal_ddr_pkg.sv
// sal_ddr_pkg: DDR command type, class priorities and DFI command encoding shared by the arbiter.
package sal_ddr_pkg;
    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4
    } cmd_t;
    localparam logic [1:0] PRIO_CAS = 2'd0;
    localparam logic [1:0] PRIO_ACT = 2'd1;
    localparam logic [1:0] PRIO_PRE = 2'd2;
    // {ras_n, cas_n, we_n}
    localparam logic [2:0] DFI_NOP = 3'b111;
    localparam logic [2:0] DFI_ACT = 3'b011;
    localparam logic [2:0] DFI_RD  = 3'b101;
    localparam logic [2:0] DFI_WR  = 3'b100;
    localparam logic [2:0] DFI_PRE = 3'b010;
    function automatic logic [2:0] dfi_enc(input cmd_t c);
        return (c == CMD_ACT) ? DFI_ACT :
               (c == CMD_RD)  ? DFI_RD  :
               (c == CMD_WR)  ? DFI_WR  :
               (c == CMD_PRE) ? DFI_PRE : DFI_NOP;
    endfunction
endpackage

// File: rtl/sal_cmd_arb_if.sv
// sal_cmd_arb_if: per-bank command request/grant bundle between bank controllers and the arbiter.
interface sal_cmd_arb_if #(
    parameter int BK_CNT = 8,
    parameter int ADDR_W = 14
);
    logic [BK_CNT-1:0]        req_valid_i;
    logic [BK_CNT*3-1:0]      req_cmd_i;
    logic [BK_CNT*ADDR_W-1:0] req_addr_i;
    logic [BK_CNT-1:0]        gnt_o;
    modport master (output req_valid_i, req_cmd_i, req_addr_i, input gnt_o);
    modport slave  (input req_valid_i, req_cmd_i, req_addr_i, output gnt_o);
endinterface

// File: rtl/SAL_RR_ARB.sv
// SAL_RR_ARB: combinational round-robin picker, first set request at or after i_ptr wins.
module SAL_RR_ARB #(
    parameter int N  = 8,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);
    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_back;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_pick;
    // rotate so the pointer sits at bit 0, isolate lowest set bit, rotate back
    always_comb begin
        w_dbl  = {i_req, i_req} >> i_ptr;
        w_rot  = w_dbl[N-1:0];
        w_pick = w_rot & (~w_rot + N'(1));
        w_back = {w_pick, w_pick} << i_ptr;
        o_gnt  = w_back[2*N-1:N];
    end
endmodule

// File: rtl/sal_cmd_arb.sv
// sal_cmd_arb: DDR command arbiter with CAS>ACT>PRE priority, timing guards and a registered DFI command.
module sal_cmd_arb
    import sal_ddr_pkg::*;
#(
    parameter int BK_CNT = 8,
    parameter int ADDR_W = 14,
    parameter int BA_W   = $clog2(BK_CNT),
    parameter int TW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    sal_cmd_arb_if.slave      bus,
    input  logic [TW-1:0]     t_ccd_i,
    input  logic [TW-1:0]     t_rrd_i,
    input  logic [TW-1:0]     t_wtr_i,
    input  logic [TW-1:0]     t_rtw_i,
    output logic              dfi_cs_n_o,
    output logic              dfi_ras_n_o,
    output logic              dfi_cas_n_o,
    output logic              dfi_we_n_o,
    output logic [BA_W-1:0]   dfi_bank_o,
    output logic [ADDR_W-1:0] dfi_address_o
);
    logic [BK_CNT-1:0] w_cas_el, w_act_el, w_pre_el;
    logic [BK_CNT-1:0] w_gnt_cas, w_gnt_act, w_gnt_pre, w_gnt;
    logic [TW-1:0]     r_ccd, r_rrd, r_wtr, r_rtw;
    logic [BA_W-1:0]   r_rr_ptr, w_win;
    logic [ADDR_W-1:0] w_addr;
    logic              w_any, w_rd, w_wr, w_act;
    cmd_t              w_cmd;
    logic              r_cs_n, r_ras_n, r_cas_n, r_we_n;
    logic [BA_W-1:0]   r_bank;
    logic [ADDR_W-1:0] r_addr;

    // max(x,1)-1 doubles as both the load value and the saturating decrement
    function automatic logic [TW-1:0] f_dec(input logic [TW-1:0] x);
        return (x == '0) ? '0 : x - TW'(1);
    endfunction

    for (genvar g = 0; g < BK_CNT; g++) begin : g_el
        logic [2:0] w_c;
        assign w_c         = bus.req_cmd_i[g*3 +: 3];
        assign w_cas_el[g] = bus.req_valid_i[g] && r_ccd == '0 &&
                             ((w_c == CMD_RD && r_wtr == '0) || (w_c == CMD_WR && r_rtw == '0));
        assign w_act_el[g] = bus.req_valid_i[g] && w_c == CMD_ACT && r_rrd == '0;
        assign w_pre_el[g] = bus.req_valid_i[g] && w_c == CMD_PRE;
    end

    SAL_RR_ARB #(.N(BK_CNT), .PW(BA_W)) u_rr_cas (.i_req(w_cas_el), .i_ptr(r_rr_ptr), .o_gnt(w_gnt_cas));
    SAL_RR_ARB #(.N(BK_CNT), .PW(BA_W)) u_rr_act (.i_req(w_act_el), .i_ptr(r_rr_ptr), .o_gnt(w_gnt_act));
    SAL_RR_ARB #(.N(BK_CNT), .PW(BA_W)) u_rr_pre (.i_req(w_pre_el), .i_ptr(r_rr_ptr), .o_gnt(w_gnt_pre));

    assign w_gnt     = rst         ? '0        :
                       |w_cas_el   ? w_gnt_cas :
                       |w_act_el   ? w_gnt_act : w_gnt_pre;
    assign w_any     = |w_gnt;
    assign bus.gnt_o = w_gnt;

    always_comb begin
        w_win  = '0;
        w_cmd  = CMD_NOP;
        w_addr = '0;
        for (int i = 0; i < BK_CNT; i++) begin
            if (w_gnt[i]) begin
                w_win  = BA_W'(i);
                w_cmd  = cmd_t'(bus.req_cmd_i[i*3 +: 3]);
                w_addr = bus.req_addr_i[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_rd  = w_any && w_cmd == CMD_RD;
    assign w_wr  = w_any && w_cmd == CMD_WR;
    assign w_act = w_any && w_cmd == CMD_ACT;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ccd    <= '0;
            r_rrd    <= '0;
            r_wtr    <= '0;
            r_rtw    <= '0;
            r_rr_ptr <= '0;
            r_cs_n   <= 1'b1;
            {r_ras_n, r_cas_n, r_we_n} <= DFI_NOP;
            r_bank   <= '0;
            r_addr   <= '0;
        end else begin
            r_ccd    <= (w_rd || w_wr) ? f_dec(t_ccd_i) : f_dec(r_ccd);
            r_rtw    <= w_rd  ? f_dec(t_rtw_i) : f_dec(r_rtw);
            r_wtr    <= w_wr  ? f_dec(t_wtr_i) : f_dec(r_wtr);
            r_rrd    <= w_act ? f_dec(t_rrd_i) : f_dec(r_rrd);
            if (w_any)
                r_rr_ptr <= (w_win == BA_W'(BK_CNT - 1)) ? '0 : w_win + BA_W'(1);
            r_cs_n   <= ~w_any;
            {r_ras_n, r_cas_n, r_we_n} <= dfi_enc(w_cmd);
            r_bank   <= w_win;
            r_addr   <= w_addr;
        end
    end

    assign dfi_cs_n_o    = r_cs_n;
    assign dfi_ras_n_o   = r_ras_n;
    assign dfi_cas_n_o   = r_cas_n;
    assign dfi_we_n_o    = r_we_n;
    assign dfi_bank_o    = r_bank;
    assign dfi_address_o = r_addr;
endmodule

// File: tb/tb_sal_cmd_arb.sv
// tb_sal_cmd_arb: directed scenario tests for the DDR command arbiter.
module tb_sal_cmd_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  t_ccd = '0, t_rrd = '0, t_wtr = '0, t_rtw = '0;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [2:0]  bank;
    logic [13:0] addr;
    logic [3:0]  dfi;
    int          n_chk = 0;
    int          n_pass = 0;

    sal_cmd_arb_if #(.BK_CNT(8), .ADDR_W(14)) bus ();

    sal_cmd_arb #(.BK_CNT(8), .ADDR_W(14), .BA_W(3), .TW(4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .t_ccd_i(t_ccd), .t_rrd_i(t_rrd), .t_wtr_i(t_wtr), .t_rtw_i(t_rtw),
        .dfi_cs_n_o(cs_n), .dfi_ras_n_o(ras_n), .dfi_cas_n_o(cas_n), .dfi_we_n_o(we_n),
        .dfi_bank_o(bank), .dfi_address_o(addr)
    );

    assign dfi = {cs_n, ras_n, cas_n, we_n};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int b, input logic [2:0] c, input logic [13:0] a);
        bus.req_valid_i[b]       = 1'b1;
        bus.req_cmd_i[b*3 +: 3]  = c;
        bus.req_addr_i[b*14 +: 14] = a;
    endtask

    task automatic clr_req(input int b);
        bus.req_valid_i[b]       = 1'b0;
        bus.req_cmd_i[b*3 +: 3]  = 3'd0;
        bus.req_addr_i[b*14 +: 14] = '0;
    endtask

    task automatic clr_all();
        for (int b = 0; b < 8; b++) clr_req(b);
    endtask

    task automatic rst_dut();
        rst = 1'b1;
        clr_all();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_all();
        set_req(0, 3'd4, 14'h055);
        tick();
        tick();
        mid();
        n_chk++; if (bus.gnt_o !== 8'h00) $display("FAIL reset_gnt: got %h want %h", bus.gnt_o, 8'h00); else n_pass++;
        n_chk++; if (dfi !== 4'hF) $display("FAIL reset_dfi: got %b want %b", dfi, 4'hF); else n_pass++;
        n_chk++; if (bank !== 3'd0 || addr !== 14'h0) $display("FAIL reset_bank_addr: got %h/%h want 0/0", bank, addr); else n_pass++;
        tick();
        rst = 1'b0;
        mid();
        n_chk++; if (bus.gnt_o !== 8'h01) $display("FAIL reset_first_gnt: got %h want %h", bus.gnt_o, 8'h01); else n_pass++;
        tick();
        clr_req(0);
        mid();
        n_chk++; if (dfi !== 4'b0010 || bank !== 3'd0 || addr !== 14'h055) $display("FAIL reset_first_dfi: got %b/%h/%h want 0010/0/055", dfi, bank, addr); else n_pass++;
    endtask

    task automatic test_ccd();
        t_ccd = 4'd4; t_rrd = 0; t_wtr = 0; t_rtw = 0;
        rst_dut();
        set_req(0, 3'd2, 14'h010);
        set_req(1, 3'd2, 14'h020);
        mid();
        n_chk++; if (bus.gnt_o !== 8'h01) $display("FAIL ccd_gnt_c0: got %h want %h", bus.gnt_o, 8'h01); else n_pass++;
        tick();
        clr_req(0);
        mid();
        n_chk++; if (dfi !== 4'b0101 || bank !== 3'd0 || addr !== 14'h010) $display("FAIL ccd_dfi_c1: got %b/%h/%h want 0101/0/010", dfi, bank, addr); else n_pass++;
        for (int c = 1; c < 4; c++) begin
            n_chk++; if (bus.gnt_o !== 8'h00) $display("FAIL ccd_hold_c%0d: got %h want %h", c, bus.gnt_o, 8'h00); else n_pass++;
            tick();
            mid();
        end
        n_chk++; if (bus.gnt_o !== 8'h02) $display("FAIL ccd_gnt_c4: got %h want %h", bus.gnt_o, 8'h02); else n_pass++;
        n_chk++; if (cas_n !== 1'b1) $display("FAIL ccd_cas_idle_c4: got %b want 1", cas_n); else n_pass++;
        tick();
        clr_req(1);
        mid();
        n_chk++; if (dfi !== 4'b0101 || bank !== 3'd1 || addr !== 14'h020) $display("FAIL ccd_dfi_c5: got %b/%h/%h want 0101/1/020", dfi, bank, addr); else n_pass++;
    endtask

    task automatic test_wtr();
        t_ccd = 4'd1; t_rrd = 0; t_wtr = 4'd6; t_rtw = 0;
        rst_dut();
        set_req(2, 3'd3, 14'h100);
        set_req(3, 3'd2, 14'h200);
        set_req(4, 3'd1, 14'h300);
        mid();
        n_chk++; if (bus.gnt_o !== 8'h04) $display("FAIL wtr_gnt_c0: got %h want %h", bus.gnt_o, 8'h04); else n_pass++;
        tick();
        clr_req(2);
        mid();
        n_chk++; if (bus.gnt_o !== 8'h10) $display("FAIL wtr_act_c1: got %h want %h", bus.gnt_o, 8'h10); else n_pass++;
        n_chk++; if (dfi !== 4'b0100 || bank !== 3'd2 || addr !== 14'h100) $display("FAIL wtr_dfi_wr: got %b/%h/%h want 0100/2/100", dfi, bank, addr); else n_pass++;
        tick();
        clr_req(4);
        mid();
        n_chk++; if (dfi !== 4'b0011 || bank !== 3'd4 || addr !== 14'h300) $display("FAIL wtr_dfi_act: got %b/%h/%h want 0011/4/300", dfi, bank, addr); else n_pass++;
        for (int c = 2; c < 6; c++) begin
            n_chk++; if (bus.gnt_o !== 8'h00) $display("FAIL wtr_hold_c%0d: got %h want %h", c, bus.gnt_o, 8'h00); else n_pass++;
            tick();
            mid();
        end
        n_chk++; if (bus.gnt_o !== 8'h08) $display("FAIL wtr_rd_c6: got %h want %h", bus.gnt_o, 8'h08); else n_pass++;
        tick();
        clr_req(3);
        mid();
        n_chk++; if (dfi !== 4'b0101 || bank !== 3'd3 || addr !== 14'h200) $display("FAIL wtr_dfi_rd: got %b/%h/%h want 0101/3/200", dfi, bank, addr); else n_pass++;
    endtask

    task automatic test_rr_pre();
        t_ccd = 0; t_rrd = 0; t_wtr = 0; t_rtw = 0;
        rst_dut();
        for (int b = 0; b < 8; b++) set_req(b, 3'd4, 14'(b * 16 + 1));
        mid();
        for (int k = 0; k < 10; k++) begin
            n_chk++; if (bus.gnt_o !== 8'(1 << (k % 8))) $display("FAIL rr_gnt_%0d: got %h want %h", k, bus.gnt_o, 8'(1 << (k % 8))); else n_pass++;
            if (k > 0) begin
                n_chk++; if (dfi !== 4'b0010 || bank !== 3'((k - 1) % 8)) $display("FAIL rr_dfi_%0d: got %b/%h want 0010/%0d", k, dfi, bank, (k - 1) % 8); else n_pass++;
            end
            tick();
            mid();
        end
        clr_all();
    endtask

    task automatic test_prio();
        t_ccd = 0; t_rrd = 0; t_wtr = 0; t_rtw = 0;
        rst_dut();
        set_req(5, 3'd2, 14'h0A5);
        set_req(1, 3'd1, 14'h3C1);
        mid();
        n_chk++; if (bus.gnt_o !== 8'h20) $display("FAIL prio_cas: got %h want %h", bus.gnt_o, 8'h20); else n_pass++;
        tick();
        clr_req(5);
        mid();
        n_chk++; if (bus.gnt_o !== 8'h02) $display("FAIL prio_act: got %h want %h", bus.gnt_o, 8'h02); else n_pass++;
        n_chk++; if (dfi !== 4'b0101 || bank !== 3'd5 || addr !== 14'h0A5) $display("FAIL prio_dfi_rd: got %b/%h/%h want 0101/5/0a5", dfi, bank, addr); else n_pass++;
        tick();
        clr_req(1);
        mid();
        n_chk++; if (dfi !== 4'b0011 || bank !== 3'd1 || addr !== 14'h3C1) $display("FAIL prio_dfi_act: got %b/%h/%h want 0011/1/3c1", dfi, bank, addr); else n_pass++;
    endtask

    task automatic test_rst_mid();
        t_ccd = 0; t_rrd = 4'd3; t_wtr = 0; t_rtw = 0;
        rst_dut();
        set_req(0, 3'd1, 14'h111);
        set_req(6, 3'd1, 14'h666);
        mid();
        n_chk++; if (bus.gnt_o !== 8'h01) $display("FAIL rstm_gnt_c0: got %h want %h", bus.gnt_o, 8'h01); else n_pass++;
        tick();
        clr_req(0);
        set_req(3, 3'd4, 14'h033);
        rst = 1'b1;
        mid();
        n_chk++; if (bus.gnt_o !== 8'h00) $display("FAIL rstm_gnt_in_rst: got %h want %h", bus.gnt_o, 8'h00); else n_pass++;
        n_chk++; if (dfi !== 4'b0011 || bank !== 3'd0 || addr !== 14'h111) $display("FAIL rstm_dfi_act: got %b/%h/%h want 0011/0/111", dfi, bank, addr); else n_pass++;
        tick();
        rst = 1'b0;
        mid();
        n_chk++; if (dfi !== 4'hF || bank !== 3'd0 || addr !== 14'h0) $display("FAIL rstm_dfi_nop: got %b/%h/%h want 1111/0/000", dfi, bank, addr); else n_pass++;
        n_chk++; if (bus.gnt_o !== 8'h40) $display("FAIL rstm_first_gnt: got %h want %h", bus.gnt_o, 8'h40); else n_pass++;
        tick();
        clr_req(6);
        mid();
        n_chk++; if (bus.gnt_o !== 8'h08) $display("FAIL rstm_pre: got %h want %h", bus.gnt_o, 8'h08); else n_pass++;
        n_chk++; if (dfi !== 4'b0011 || bank !== 3'd6 || addr !== 14'h666) $display("FAIL rstm_dfi_act6: got %b/%h/%h want 0011/6/666", dfi, bank, addr); else n_pass++;
        tick();
        clr_req(3);
    endtask

    task automatic test_back_to_back();
        t_ccd = 0; t_rrd = 0; t_wtr = 0; t_rtw = 0;
        rst_dut();
        set_req(0, 3'd2, 14'h001);
        set_req(1, 3'd3, 14'h002);
        set_req(2, 3'd2, 14'h003);
        mid();
        n_chk++; if (bus.gnt_o !== 8'h01) $display("FAIL b2b_gnt_c0: got %h want %h", bus.gnt_o, 8'h01); else n_pass++;
        tick();
        clr_req(0);
        mid();
        n_chk++; if (bus.gnt_o !== 8'h02) $display("FAIL b2b_gnt_c1: got %h want %h", bus.gnt_o, 8'h02); else n_pass++;
        n_chk++; if (dfi !== 4'b0101 || bank !== 3'd0) $display("FAIL b2b_dfi_c1: got %b/%h want 0101/0", dfi, bank); else n_pass++;
        tick();
        clr_req(1);
        mid();
        n_chk++; if (bus.gnt_o !== 8'h04) $display("FAIL b2b_gnt_c2: got %h want %h", bus.gnt_o, 8'h04); else n_pass++;
        n_chk++; if (dfi !== 4'b0100 || bank !== 3'd1) $display("FAIL b2b_dfi_c2: got %b/%h want 0100/1", dfi, bank); else n_pass++;
        tick();
        clr_req(2);
        mid();
        n_chk++; if (dfi !== 4'b0101 || bank !== 3'd2 || addr !== 14'h003) $display("FAIL b2b_dfi_c3: got %b/%h/%h want 0101/2/003", dfi, bank, addr); else n_pass++;
        n_chk++; if (bus.gnt_o !== 8'h00) $display("FAIL b2b_gnt_c3: got %h want %h", bus.gnt_o, 8'h00); else n_pass++;
        tick();
        mid();
        n_chk++; if (dfi !== 4'hF || bank !== 3'd0 || addr !== 14'h0) $display("FAIL b2b_idle_nop: got %b/%h/%h want 1111/0/000", dfi, bank, addr); else n_pass++;
    endtask

    initial begin
        clr_all();
        test_reset();
        test_ccd();
        test_wtr();
        test_rr_pre();
        test_prio();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sal_cmd_arb.md
SAL_CMD_ARB -- requirements
Module: sal_cmd_arb

Interface
REQ-001 SHALL have parameter BK_CNT, default 8, number of bank-controller requesters; the requester index is the DRAM bank.
REQ-002 SHALL have parameter ADDR_W, default 14, DRAM row/column address width.
REQ-003 SHALL have parameter BA_W, default 3, bank address width, equal to $clog2(BK_CNT).
REQ-004 SHALL have parameter TW, default 4, timing-field width.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 req_valid_i  in  BK_CNT  per-bank command request.
REQ-009 req_cmd_i  in  BK_CNT*3  per-bank cmd_t: NOP=0, ACT=1, RD=2, WR=3, PRE=4.
REQ-010 req_addr_i  in  BK_CNT*ADDR_W  per-bank row (ACT) or column (RD/WR/PRE) address.
REQ-011 gnt_o  out  BK_CNT  one-hot combinational grant.
REQ-012 t_ccd_i, t_rrd_i, t_wtr_i, t_rtw_i  in  TW each  minimum spacing in cycles: CAS-CAS, ACT-ACT, WR-RD, RD-WR.
REQ-013 dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o  out  1 each  registered DFI command.
REQ-014 dfi_bank_o  out  BA_W  registered bank; dfi_address_o  out  ADDR_W  registered address.

Function
REQ-015 Handshake: a requester SHALL hold valid, cmd and addr stable until granted; gnt_o is a single-cycle pulse, and valid may drop only after the grant.
REQ-016 At most one grant per cycle; a granted command SHALL appear on the DFI outputs on the next cycle (latency 1).
REQ-017 Eligibility: RD needs ccd_cnt==0 and wtr_cnt==0; WR needs ccd_cnt==0 and rtw_cnt==0; ACT needs rrd_cnt==0; PRE is always eligible; NOP or invalid cmd codes are never granted.
REQ-018 Priority: CAS (RD/WR) over ACT over PRE, evaluated over eligible requests only; an ineligible higher-class request SHALL NOT block a lower class.
REQ-019 Within a class: round-robin starting at rr_ptr; after any grant, rr_ptr <= winner+1 modulo BK_CNT.
REQ-020 Counters: on issue, load the relevant counter(s) with max(t,1)-1; otherwise decrement while nonzero. t=0 or t=1 permits back-to-back issue.
REQ-021 Counter loads: RD loads ccd and rtw; WR loads ccd and wtr; ACT loads rrd.
REQ-022 A timing input change affects only subsequent loads; running counters are not modified.
REQ-023 DFI encoding (ras_n, cas_n, we_n), cs_n=0 on issue: ACT 0,1,1; RD 1,0,1; WR 1,0,0; PRE 0,1,0. bank = winner index; address = winner addr.
REQ-024 Cycles with no grant SHALL drive NOP: cs_n, ras_n, cas_n and we_n all 1, bank 0, address 0.
REQ-025 With all BK_CNT requesting the same class and eligible every cycle, each bank SHALL be granted exactly once per BK_CNT grants.

Reset
REQ-026 While rst=1: gnt_o=0, all counters 0, rr_ptr 0, DFI outputs NOP (cs_n, ras_n, cas_n, we_n = 1, bank 0, address 0).
REQ-027 Reset asserted mid-operation SHALL discard any pending grant; the first grant is possible in the first cycle after rst deasserts.

Structure
REQ-028 cmd_t, class priority constants and the DFI encoding table SHALL live in shared package sal_ddr_pkg.
REQ-029 Round-robin selection SHALL be sub-module SAL_RR_ARB (BK_CNT-bit request vector plus pointer in, one-hot grant out, combinational), instantiated once per class.
REQ-030 All timing counters and DFI output registers SHALL reside in sal_cmd_arb.

Verification
REQ-031 t_ccd=4; bank0 RD at cycle 0, bank1 RD pending -> bank1 granted at cycle 4; dfi_cas_n low at cycles 1 and 5.
REQ-032 t_wtr=6, t_ccd=1; bank2 WR at cycle 0, bank3 RD pending plus bank4 ACT -> ACT granted at cycle 1, RD granted at cycle 6.
REQ-033 All 8 banks PRE continuously, rr_ptr=0 -> grants 0,1,...,7,0 on consecutive cycles; dfi_bank_o follows one cycle later.
REQ-034 Bank5 RD eligible and bank1 ACT simultaneously, t_rrd=0 -> bank5 granted first, bank1 on the next cycle.
REQ-035 t_rrd=3; ACT issued, rst pulsed 1 cycle later -> all DFI outputs NOP, and a pending ACT is granted in the first cycle after rst deasserts.
REQ-036 All timings 0 -> back-to-back RD/WR/RD from banks 0,1,2 granted on cycles 0,1,2 with encodings 101, 100, 101.
